// File: rtl/character_action_controller.sv
// Character action controller: turns debounced buttons and physics feedback into
// a jump-oriented character state machine that advances once per character_clk tick.
module character_action_controller #(
    parameter int SIGNED_PHY_WIDTH = 17,
    parameter int REFRESH_RATE     = 64,
    parameter int MAX_CHARGE       = REFRESH_RATE,
    parameter int CHARGE_WIDTH     = $clog2(MAX_CHARGE + 1),
    parameter int LAND_TIME        = REFRESH_RATE >> 2
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic                               character_clk,
    input  logic                               btn_left,
    input  logic                               btn_right,
    input  logic                               btn_jump,
    input  logic                               on_ground,
    input  logic                               hit_wall,
    input  logic signed [SIGNED_PHY_WIDTH-1:0] vel_y,
    output logic [2:0]                         char_state,
    output logic [CHARGE_WIDTH-1:0]            jump_charge,
    output logic                               jump_fire,
    output logic [1:0]                         jump_dir
);
    localparam int LAND_WIDTH = (LAND_TIME > 1) ? $clog2(LAND_TIME) : 1;
    localparam logic [CHARGE_WIDTH-1:0] CHARGE_MAX = CHARGE_WIDTH'(MAX_CHARGE);
    localparam logic [LAND_WIDTH-1:0]   LAND_LAST  = LAND_WIDTH'(LAND_TIME - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEFT      = 3'd1,
        ST_RIGHT     = 3'd2,
        ST_CHARGE    = 3'd3,
        ST_JUMP      = 3'd4,
        ST_COLLISION = 3'd5,
        ST_FALL      = 3'd6,
        ST_HOLD      = 3'd7
    } state_t;

    logic                               char_clk_q, btn_left_q, btn_right_q, btn_jump_q;
    logic                               on_ground_q, hit_wall_q;
    logic signed [SIGNED_PHY_WIDTH-1:0] vel_y_q;

    state_t                  state_q, state_d;
    logic [CHARGE_WIDTH-1:0] charge_cnt_q, charge_cnt_d;
    logic [LAND_WIDTH-1:0]   land_cnt_q, land_cnt_d;
    logic [CHARGE_WIDTH-1:0] jump_charge_q, jump_charge_d;
    logic [1:0]              jump_dir_q, jump_dir_d;
    logic                    jump_fire_q, jump_fire_d;
    logic                    armed_q, armed_d;
    logic                    tick;
    logic                    descending;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            char_clk_q  <= 1'b0;
            btn_left_q  <= 1'b0;
            btn_right_q <= 1'b0;
            btn_jump_q  <= 1'b0;
            on_ground_q <= 1'b0;
            hit_wall_q  <= 1'b0;
            vel_y_q     <= '0;
        end else begin
            char_clk_q  <= character_clk;
            btn_left_q  <= btn_left;
            btn_right_q <= btn_right;
            btn_jump_q  <= btn_jump;
            on_ground_q <= on_ground;
            hit_wall_q  <= hit_wall;
            vel_y_q     <= vel_y;
        end
    end

    // The first registered tick after reset only arms the machine, so input
    // registers that were cleared by reset never drive a decision.
    assign tick       = char_clk_q && armed_q;
    assign descending = vel_y_q[SIGNED_PHY_WIDTH-1] || (vel_y_q == '0);

    always_comb begin
        state_d       = state_q;
        charge_cnt_d  = charge_cnt_q;
        land_cnt_d    = land_cnt_q;
        jump_charge_d = jump_charge_q;
        jump_dir_d    = jump_dir_q;
        jump_fire_d   = 1'b0;
        armed_d       = armed_q | char_clk_q;

        if (tick) begin
            charge_cnt_d = '0;
            land_cnt_d   = '0;
            case (state_q)
                ST_IDLE, ST_LEFT, ST_RIGHT: begin
                    if (!on_ground_q) begin
                        state_d = ST_JUMP;
                    end else if (btn_jump_q) begin
                        state_d      = ST_CHARGE;
                        charge_cnt_d = CHARGE_WIDTH'(1);
                    end else if (btn_left_q && !btn_right_q) begin
                        state_d = ST_LEFT;
                    end else if (btn_right_q && !btn_left_q) begin
                        state_d = ST_RIGHT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CHARGE: begin
                    if (!on_ground_q) begin
                        state_d = ST_JUMP;
                    end else if (!btn_jump_q || (charge_cnt_q == CHARGE_MAX)) begin
                        state_d       = ST_JUMP;
                        jump_fire_d   = 1'b1;
                        jump_charge_d = charge_cnt_q;
                        jump_dir_d    = {btn_right_q && !btn_left_q, btn_left_q && !btn_right_q};
                    end else begin
                        // Reaching CHARGE_MAX always launches, so this never overflows.
                        charge_cnt_d = charge_cnt_q + 1'b1;
                    end
                end
                ST_JUMP: begin
                    if (hit_wall_q) begin
                        state_d = ST_COLLISION;
                    end else if (on_ground_q && descending) begin
                        state_d = ST_FALL;
                    end
                end
                ST_COLLISION: begin
                    state_d = on_ground_q ? ST_FALL : ST_JUMP;
                end
                ST_FALL: begin
                    if (!on_ground_q) begin
                        state_d = ST_JUMP;
                    end else if (land_cnt_q == LAND_LAST) begin
                        state_d = btn_jump_q ? ST_HOLD : ST_IDLE;
                    end else begin
                        land_cnt_d = land_cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!btn_jump_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            charge_cnt_q  <= '0;
            land_cnt_q    <= '0;
            jump_charge_q <= '0;
            jump_dir_q    <= 2'b00;
            jump_fire_q   <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            charge_cnt_q  <= charge_cnt_d;
            land_cnt_q    <= land_cnt_d;
            jump_charge_q <= jump_charge_d;
            jump_dir_q    <= jump_dir_d;
            jump_fire_q   <= jump_fire_d;
            armed_q       <= armed_d;
        end
    end

    assign char_state  = state_q;
    assign jump_charge = jump_charge_q;
    assign jump_fire   = jump_fire_q;
    assign jump_dir    = jump_dir_q;

endmodule

// File: tb/tb_character_action_controller.sv
// Self-checking bench for character_action_controller: directed scenarios plus
// randomized ticks compared against a behavioural model of the character rules.
module tb_character_action_controller;
    localparam int PW   = 17;
    localparam int RR   = 64;
    localparam int MAXC = RR;
    localparam int CW   = 7;
    localparam int LT   = RR >> 2;

    localparam int S_IDLE = 0, S_LEFT = 1, S_RIGHT = 2, S_CHARGE = 3;
    localparam int S_JUMP = 4, S_COLL = 5, S_FALL = 6, S_HOLD = 7;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic                 character_clk = 1'b0;
    logic                 btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
    logic                 on_ground = 1'b0, hit_wall = 1'b0;
    logic signed [PW-1:0] vel_y = '0;
    logic [2:0]           char_state;
    logic [CW-1:0]        jump_charge;
    logic                 jump_fire;
    logic [1:0]           jump_dir;

    int compared   = 0;
    int mismatched = 0;
    int fire_count = 0;
    bit fire_seen;

    int m_state, m_charge, m_land, m_jcharge, m_jdir;
    bit m_armed, m_fire;

    character_action_controller dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .character_clk(character_clk),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_jump     (btn_jump),
        .on_ground    (on_ground),
        .hit_wall     (hit_wall),
        .vel_y        (vel_y),
        .char_state   (char_state),
        .jump_charge  (jump_charge),
        .jump_fire    (jump_fire),
        .jump_dir     (jump_dir)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        m_state = S_IDLE; m_charge = 0; m_land = 0;
        m_jcharge = 0; m_jdir = 0; m_armed = 0; m_fire = 0;
    endfunction

    // One character tick of the behavioural model, using the inputs held during the tick.
    function automatic void modelTick();
        bit l, r, j, g, w;
        int v;
        l = btn_left; r = btn_right; j = btn_jump; g = on_ground; w = hit_wall;
        v = int'(vel_y);
        m_fire = 0;
        if (!m_armed) begin
            m_armed = 1;
            return;
        end
        case (m_state)
            S_IDLE, S_LEFT, S_RIGHT: begin
                if (!g)            m_state = S_JUMP;
                else if (j)        begin m_state = S_CHARGE; m_charge = 1; end
                else if (l && !r)  m_state = S_LEFT;
                else if (r && !l)  m_state = S_RIGHT;
                else               m_state = S_IDLE;
            end
            S_CHARGE: begin
                if (!g) begin
                    m_state = S_JUMP; m_charge = 0;
                end else if (!j || m_charge == MAXC) begin
                    m_jcharge = m_charge;
                    m_jdir    = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
                    m_fire    = 1;
                    m_state   = S_JUMP;
                    m_charge  = 0;
                end else begin
                    m_charge = (m_charge + 1 > MAXC) ? MAXC : m_charge + 1;
                end
            end
            S_JUMP: begin
                if (w)                  m_state = S_COLL;
                else if (g && v <= 0)   begin m_state = S_FALL; m_land = 0; end
            end
            S_COLL: begin
                if (g) begin m_state = S_FALL; m_land = 0; end
                else   m_state = S_JUMP;
            end
            S_FALL: begin
                if (!g) m_state = S_JUMP;
                else begin
                    m_land++;
                    if (m_land == LT) m_state = j ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: if (!j) m_state = S_IDLE;
            default: m_state = S_IDLE;
        endcase
    endfunction

    // Drives one character tick and checks all outputs against the model.
    task automatic applyStimulus(input logic l, input logic r, input logic j,
                                 input logic g, input logic w, input int v);
        btn_left = l; btn_right = r; btn_jump = j; on_ground = g; hit_wall = w;
        vel_y = v[PW-1:0];
        character_clk = 1'b1;
        @(posedge sys_clk); #1;
        character_clk = 1'b0;
        @(posedge sys_clk); #1;
        modelTick();
        fire_seen = jump_fire;
        if (jump_fire === 1'b1) fire_count++;
        checkOutput("state", 32'(char_state), m_state);
        checkOutput("fire", 32'(jump_fire), 32'(m_fire));
        checkOutput("jump_charge", 32'(jump_charge), m_jcharge);
        checkOutput("jump_dir", 32'(jump_dir), m_jdir);
        @(posedge sys_clk); #1;
        checkOutput("fire_width", 32'(jump_fire), 0);
    endtask

    task automatic doReset();
        sys_rst_n = 1'b0;
        btn_left = 0; btn_right = 0; btn_jump = 0; on_ground = 0; hit_wall = 0;
        vel_y = '0; character_clk = 1'b0;
        repeat (3) begin
            @(posedge sys_clk); #1;
            checkOutput("fire_in_reset", 32'(jump_fire), 0);
        end
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        modelReset();
    endtask

    initial begin
        int n, fires_before;
        logic rl, rr, rj, rg, rw;
        int rv;

        modelReset();
        #2;
        doReset();
        checkOutput("reset_state", 32'(char_state), S_IDLE);
        checkOutput("reset_charge", 32'(jump_charge), 0);
        checkOutput("reset_dir", 32'(jump_dir), 0);
        checkOutput("reset_fire", 32'(jump_fire), 0);

        // First tick after release must not change state.
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("first_tick_hold", 32'(char_state), S_IDLE);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("second_tick_left", 32'(char_state), S_LEFT);
        applyStimulus(0, 0, 0, 1, 0, 0);

        // Both directions together stay IDLE; left alone moves LEFT.
        applyStimulus(1, 1, 0, 1, 0, 0);
        checkOutput("both_dirs_idle", 32'(char_state), S_IDLE);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("left_alone", 32'(char_state), S_LEFT);
        applyStimulus(0, 0, 0, 1, 0, 0);

        // Ten ticks of charge, then release.
        n = 0;
        fires_before = fire_count;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, 1, 0, 0);
            if (char_state == 3'(S_CHARGE)) n++;
        end
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("charge_ticks_10", n, 10);
        checkOutput("fire_pulses_10", fire_count - fires_before, 1);
        checkOutput("jump_charge_10", 32'(jump_charge), 10);
        checkOutput("jump_dir_10", 32'(jump_dir), 0);
        checkOutput("state_after_10", 32'(char_state), S_JUMP);
        repeat (20) applyStimulus(0, 0, 0, 1, 0, 0);

        // Held jump and right launch at saturation.
        n = 0;
        for (int i = 0; i < 80; i++) begin
            applyStimulus(0, 1, 1, 1, 0, 5);
            n++;
            if (fire_seen) break;
        end
        checkOutput("sat_launch_tick", n, MAXC + 1);
        checkOutput("jump_charge_max", 32'(jump_charge), MAXC);
        checkOutput("jump_dir_right", 32'(jump_dir), 2);

        // Landing with jump still held ends in HOLD after LAND_TIME ticks.
        n = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 1, 1, 0, -5);
            if (char_state == 3'(S_FALL)) n++;
            else break;
        end
        checkOutput("fall_ticks", n, LT);
        checkOutput("after_fall_hold", 32'(char_state), S_HOLD);
        applyStimulus(0, 0, 1, 1, 0, -5);
        checkOutput("hold_no_recharge", 32'(char_state), S_HOLD);
        applyStimulus(0, 0, 0, 1, 0, -5);
        checkOutput("hold_release_idle", 32'(char_state), S_IDLE);

        // Wall hit while grounded: one COLLISION tick then landing.
        applyStimulus(0, 0, 0, 0, 0, 5);
        checkOutput("airborne_jump", 32'(char_state), S_JUMP);
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("collision", 32'(char_state), S_COLL);
        applyStimulus(0, 0, 0, 1, 0, 5);
        checkOutput("collision_to_fall", 32'(char_state), S_FALL);
        repeat (LT + 2) applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("landed_idle", 32'(char_state), S_IDLE);

        // Reset in the middle of a charge: asynchronous clear, no pulse.
        repeat (30) applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("charging_30", 32'(char_state), S_CHARGE);
        fires_before = fire_count;
        #3;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("async_state", 32'(char_state), S_IDLE);
        checkOutput("async_charge", 32'(jump_charge), 0);
        checkOutput("async_dir", 32'(jump_dir), 0);
        checkOutput("async_fire", 32'(jump_fire), 0);
        @(posedge sys_clk); #1;
        doReset();
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("no_fire_after_reset", fire_count - fires_before, 0);

        // Randomized ticks against the model.
        rl = 0; rr = 0; rj = 0; rg = 1; rw = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) rj = ~rj;
            if ($urandom_range(3) == 0) rl = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) rr = 1'($urandom_range(1));
            if ($urandom_range(9) == 0) rg = ~rg;
            rw = ($urandom_range(15) == 0);
            rv = int'($urandom_range(16)) - 8;
            applyStimulus(rl, rr, rj, rg, rw, rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
